vid_mixer: RTL and testbench

VID_MIXER -- requirements
Module: vid_mixer

---
 rtl/vid_mixer_pkg.sv | 18 +
 rtl/vid_mixer_cfg.sv | 82 ++++++++
 rtl/vid_mixer.sv | 81 ++++++++
 tb/tb_vid_mixer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vid_mixer_pkg.sv
// vid_mixer_pkg: command opcodes, command field positions and the shared rgb type.
package vid_mixer_pkg;
  typedef enum logic [3:0] {OP_MASK = 4'd0, OP_KEY = 4'd1, OP_BG = 4'd2} opcode_e;
  localparam int OPC_LSB   = 28;
  localparam int LAYER_LSB = 24;
  localparam int DATA_W    = 24;
  localparam int MAX_CB    = 8;
  typedef struct packed {
    logic [MAX_CB-1:0] r;
    logic [MAX_CB-1:0] g;
    logic [MAX_CB-1:0] b;
  } rgb_t;
  function automatic rgb_t split_rgb(input logic [3*MAX_CB-1:0] v, input int cb);
    logic [MAX_CB-1:0] m;
    m = MAX_CB'((32'd1 << cb) - 32'd1);
    return '{r: MAX_CB'(v >> (2 * cb)) & m, g: MAX_CB'(v >> cb) & m, b: v[MAX_CB-1:0] & m};
  endfunction
endpackage

// File: rtl/vid_mixer_cfg.sv
// vid_mixer_cfg: command decode plus shadow/active config banks swapped at frame start.
// Per-layer key registers only exist when MIXER_KEY_EN is defined; otherwise every key is 0.
module vid_mixer_cfg import vid_mixer_pkg::*; #(
  parameter int NUM_LAYERS = 2,
  parameter int COLOR_BITS = 4
) (
  input  logic                             clk,
  input  logic                             reset_n_i,
  input  logic                             frame_start_i,
  input  logic                             cmd_valid_i,
  input  logic [31:0]                      cmd_data_i,
  output logic                             cmd_ready_o,
  output logic [NUM_LAYERS-1:0]            en_o,
  output logic [NUM_LAYERS*3*COLOR_BITS-1:0] key_o,
  output logic [3*COLOR_BITS-1:0]          bg_o,
  output logic                             pending_o,
  output logic                             bad_o
);
  localparam int CW = 3 * COLOR_BITS;
  opcode_e op;
  logic [3:0] lyr;
  logic [DATA_W-1:0] dat;
  logic wr, good, bad_d, bad_q, pend_d, pend_q, unused_dat;
  logic [NUM_LAYERS-1:0] sh_en_d, sh_en_q, act_en_d, act_en_q;
  logic [CW-1:0] sh_bg_d, sh_bg_q, act_bg_d, act_bg_q;
  assign op          = opcode_e'(cmd_data_i[OPC_LSB +: 4]);
  assign lyr         = cmd_data_i[LAYER_LSB +: 4];
  assign dat         = cmd_data_i[DATA_W-1:0];
  assign unused_dat  = ^dat;
  assign cmd_ready_o = reset_n_i;
  assign wr          = cmd_valid_i & cmd_ready_o;
  assign good        = wr && lyr < 4'(NUM_LAYERS) && (op == OP_MASK || op == OP_KEY || op == OP_BG);
  always_comb begin
    bad_d    = wr & ~good;
    pend_d   = good | (pend_q & ~frame_start_i);
    sh_en_d  = (good && op == OP_MASK) ? dat[NUM_LAYERS-1:0] : sh_en_q;
    sh_bg_d  = (good && op == OP_BG) ? dat[CW-1:0] : sh_bg_q;
    act_en_d = frame_start_i ? sh_en_q : act_en_q;
    act_bg_d = frame_start_i ? sh_bg_q : act_bg_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      bad_q    <= 1'b0;
      pend_q   <= 1'b0;
      sh_en_q  <= '1;
      act_en_q <= '1;
      sh_bg_q  <= '0;
      act_bg_q <= '0;
    end else begin
      bad_q    <= bad_d;
      pend_q   <= pend_d;
      sh_en_q  <= sh_en_d;
      act_en_q <= act_en_d;
      sh_bg_q  <= sh_bg_d;
      act_bg_q <= act_bg_d;
    end
  end
`ifdef MIXER_KEY_EN
  logic [NUM_LAYERS*CW-1:0] sh_key_d, sh_key_q, act_key_d, act_key_q;
  always_comb begin
    sh_key_d = sh_key_q;
    if (good && op == OP_KEY) sh_key_d[int'(lyr)*CW +: CW] = dat[CW-1:0];
    act_key_d = frame_start_i ? sh_key_q : act_key_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      sh_key_q  <= '0;
      act_key_q <= '0;
    end else begin
      sh_key_q  <= sh_key_d;
      act_key_q <= act_key_d;
    end
  end
  assign key_o = act_key_q;
`else
  assign key_o = '0;
`endif
  assign en_o      = act_en_q;
  assign bg_o      = act_bg_q;
  assign pending_o = pend_q;
  assign bad_o     = bad_q;
endmodule

// File: rtl/vid_mixer.sv
// vid_mixer: 2-stage priority/colour-key layer mixer with frame-synchronous config.
// Optional per-layer key registers are enabled by defining MIXER_KEY_EN.
module vid_mixer import vid_mixer_pkg::*; #(
  parameter int NUM_LAYERS        = 2,
  parameter int COLOR_BITS        = 4,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                               clk,
  input  logic                               reset_n_i,
  input  logic                               vga_hsync_i,
  input  logic                               vga_vsync_i,
  input  logic                               vga_de_i,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb_i,
  input  logic                               cmd_axis_tvalid_i,
  output logic                               cmd_axis_tready_o,
  input  logic [31:0]                        cmd_axis_tdata_i,
  output logic                               vga_hsync_o,
  output logic                               vga_vsync_o,
  output logic                               vga_de_o,
  output logic [COLOR_BITS-1:0]              vga_r_o,
  output logic [COLOR_BITS-1:0]              vga_g_o,
  output logic [COLOR_BITS-1:0]              vga_b_o,
  output logic                               frame_o,
  output logic                               cfg_pending_o,
  output logic                               bad_cmd_o
);
  localparam int CW = 3 * COLOR_BITS;
  logic frame_start, pending, bad, unused_px;
  logic [NUM_LAYERS-1:0] en, opq1_d, opq1_q;
  logic [NUM_LAYERS*CW-1:0] key, rgb1_q;
  logic [CW-1:0] bg, sel, pix2_d, pix2_q;
  logic hs1_q, vs1_q, de1_q, va1_d, va1_q, va_prev_q, hs2_q, vs2_q, de2_q;
  rgb_t px;
  vid_mixer_cfg #(.NUM_LAYERS(NUM_LAYERS), .COLOR_BITS(COLOR_BITS)) u_cfg (
    .clk(clk), .reset_n_i(reset_n_i), .frame_start_i(frame_start),
    .cmd_valid_i(cmd_axis_tvalid_i), .cmd_data_i(cmd_axis_tdata_i), .cmd_ready_o(cmd_axis_tready_o),
    .en_o(en), .key_o(key), .bg_o(bg), .pending_o(pending), .bad_o(bad)
  );
  // vsync is normalised to "active" so reset (all zero) never looks like a trailing edge
  always_comb begin
    va1_d       = vga_vsync_i == 1'(VSYNC_ACTIVE_HIGH);
    frame_start = va_prev_q & ~va1_q;
    for (int n = 0; n < NUM_LAYERS; n++)
      opq1_d[n] = en[n] && (layer_rgb_i[n*CW +: CW] != key[n*CW +: CW]);
    sel = bg;
    for (int n = NUM_LAYERS - 1; n >= 0; n--)
      sel = opq1_q[n] ? rgb1_q[n*CW +: CW] : sel;
    pix2_d = de1_q ? sel : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      {hs1_q, vs1_q, de1_q, va1_q, va_prev_q, hs2_q, vs2_q, de2_q} <= '0;
      opq1_q <= '0;
      rgb1_q <= '0;
      pix2_q <= '0;
    end else begin
      hs1_q     <= vga_hsync_i;
      vs1_q     <= vga_vsync_i;
      de1_q     <= vga_de_i;
      va1_q     <= va1_d;
      va_prev_q <= va1_q;
      opq1_q    <= opq1_d;
      rgb1_q    <= layer_rgb_i;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      de2_q     <= de1_q;
      pix2_q    <= pix2_d;
    end
  end
  assign px            = split_rgb(DATA_W'(pix2_q), COLOR_BITS);
  assign unused_px     = ^px;
  assign vga_r_o       = reset_n_i ? COLOR_BITS'(px.r) : '0;
  assign vga_g_o       = reset_n_i ? COLOR_BITS'(px.g) : '0;
  assign vga_b_o       = reset_n_i ? COLOR_BITS'(px.b) : '0;
  assign vga_hsync_o   = hs2_q & reset_n_i;
  assign vga_vsync_o   = vs2_q & reset_n_i;
  assign vga_de_o      = de2_q & reset_n_i;
  assign frame_o       = frame_start & reset_n_i;
  assign cfg_pending_o = pending & reset_n_i;
  assign bad_cmd_o     = bad & reset_n_i;
endmodule

// File: tb/tb_vid_mixer.sv
// tb_vid_mixer: directed checks of vid_mixer (2 layers, 4-bit colour) plus an active-low-vsync instance.
module tb_vid_mixer;
  logic clk = 1'b0, rst_n = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0, tvalid = 1'b0;
  logic [23:0] layers = '0;
  logic [31:0] tdata = '0;
  logic tready, hs_o, vs_o, de_o, frame, pend, bad;
  logic [3:0] r, g, b;
  logic tready1, hs1, vs1, de1, frame1, pend1, bad1;
  logic [3:0] r1, g1, b1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vid_mixer u_dut (
    .clk(clk), .reset_n_i(rst_n), .vga_hsync_i(hs), .vga_vsync_i(vs), .vga_de_i(de),
    .layer_rgb_i(layers), .cmd_axis_tvalid_i(tvalid), .cmd_axis_tready_o(tready),
    .cmd_axis_tdata_i(tdata), .vga_hsync_o(hs_o), .vga_vsync_o(vs_o), .vga_de_o(de_o),
    .vga_r_o(r), .vga_g_o(g), .vga_b_o(b), .frame_o(frame), .cfg_pending_o(pend), .bad_cmd_o(bad)
  );

  vid_mixer #(.VSYNC_ACTIVE_HIGH(0)) u_low (
    .clk(clk), .reset_n_i(rst_n), .vga_hsync_i(hs), .vga_vsync_i(vs), .vga_de_i(de),
    .layer_rgb_i(layers), .cmd_axis_tvalid_i(tvalid), .cmd_axis_tready_o(tready1),
    .cmd_axis_tdata_i(tdata), .vga_hsync_o(hs1), .vga_vsync_o(vs1), .vga_de_o(de1),
    .vga_r_o(r1), .vga_g_o(g1), .vga_b_o(b1), .frame_o(frame1), .cfg_pending_o(pend1), .bad_cmd_o(bad1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    tvalid = 1'b1;
    tdata  = w;
    tick();
    tvalid = 1'b0;
  endtask

  // vsync pulse: active-low instance frames on the rising edge, active-high one on the falling edge
  task automatic frame_seq(input bit with_cmd, input logic [31:0] w);
    vs = 1'b1;
    tick();
    chk("low_frame", 32'(frame1), 1);
    chk("high_no_frame", 32'(frame), 0);
    vs = 1'b0;
    tick();
    chk("high_frame", 32'(frame), 1);
    chk("low_single", 32'(frame1), 0);
    if (with_cmd) send(w); else tick();
    chk("frame_end", 32'(frame), 0);
  endtask

  initial begin
    #1;
    chk("rst_tready", 32'(tready), 0);
    chk("rst_rgb", {20'h0, r, g, b}, 0);
    tick();
    chk("rst_sync", {29'h0, hs_o, vs_o, de_o}, 0);
    chk("rst_flags", {29'h0, frame, pend, bad}, 0);
    rst_n = 1'b1;
    tick();
    chk("tready", 32'(tready), 1);
    chk("no_frame_after_rst", 32'(frame | frame1), 0);
    // layer0 black is transparent under the default key; layer1 shows through
    de = 1'b1; hs = 1'b1; layers = 24'h5A3_000;
    tick();
    chk("lat_1cyc", {20'h0, r, g, b}, 0);
    tick();
    chk("lat_2cyc", {20'h0, r, g, b}, 12'h5A3);
    chk("sync_delay", {29'h0, hs_o, vs_o, de_o}, 3'b101);
    layers = 24'h0F0_F00;
    tick(); tick();
    chk("prio_l0", {20'h0, r, g, b}, 12'hF00);
    send(32'h0000_0002);
    chk("pend_set", 32'(pend), 1);
    tick();
    chk("mask_not_yet", {20'h0, r, g, b}, 12'hF00);
    frame_seq(1'b0, 32'h0);
    chk("pend_clr", 32'(pend), 0);
    tick(); tick();
    chk("mask_applied", {20'h0, r, g, b}, 12'h0F0);
    // write landing on the frame-start cycle goes to shadow only
    layers = 24'h000_000;
    frame_seq(1'b1, 32'h2000_0123);
    chk("pend_coincide", 32'(pend), 1);
    tick(); tick(); tick();
    chk("bg_unchanged", {20'h0, r, g, b}, 12'h000);
    frame_seq(1'b0, 32'h0);
    tick(); tick();
    chk("bg_applied", {20'h0, r, g, b}, 12'h123);
    chk("pend_clr2", 32'(pend), 0);
    send(32'h1300_0000);
    chk("bad_idx", 32'(bad), 1);
    chk("bad_no_pend", 32'(pend), 0);
    tick();
    chk("bad_pulse", 32'(bad), 0);
    send(32'h5000_0000);
    chk("bad_op", 32'(bad), 1);
    frame_seq(1'b0, 32'h0);
    tick(); tick();
    chk("bad_no_change", {20'h0, r, g, b}, 12'h123);
    de = 1'b0; hs = 1'b0; layers = 24'h0F0_F00;
    tick(); tick();
    chk("de0_rgb", {20'h0, r, g, b}, 0);
    chk("de0_sync", {29'h0, hs_o, vs_o, de_o}, 0);
    de = 1'b1;
    send(32'h0000_0003);
`ifdef MIXER_KEY_EN
    send(32'h1000_0F00);
    chk("key_ok", 32'(bad), 0);
    send(32'h2000_000F);
    layers = 24'h000_F00;
    frame_seq(1'b0, 32'h0);
    tick(); tick();
    chk("key_bg", {20'h0, r, g, b}, 12'h00F);
`else
    send(32'h1000_0F00);
    chk("key_ignored_nobad", 32'(bad), 0);
    send(32'h2000_000F);
    layers = 24'h000_F00;
    frame_seq(1'b0, 32'h0);
    tick(); tick();
    chk("key_fixed", {20'h0, r, g, b}, 12'hF00);
`endif
    // mid-line reset must drop pending shadow writes
    layers = 24'h0F0_000;
    send(32'h0000_0001);
    send(32'h2000_0777);
    chk("pend_pre_rst", 32'(pend), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {16'h0, tready, hs_o, de_o, pend, r, g, b}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_pend", 32'(pend), 0);
    chk("rst_no_frame", 32'(frame), 0);
    frame_seq(1'b0, 32'h0);
    tick(); tick();
    chk("shadow_default", {20'h0, r, g, b}, 12'h0F0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
